// File: rtl/lockstep_cfg_pkg.sv
// Shared types and constants for the lockstep peripheral-bus config initiator.
package lockstep_cfg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT_R,
    RESP,
    BOOT
  } state_e;

  // Bus write-enable is active low: 1 means read.
  localparam logic WEN_READ  = 1'b1;
  localparam logic WEN_WRITE = 1'b0;

  localparam int DEF_TIMEOUT_CYCLES = 256;

endpackage

// File: rtl/lockstep_cfg_timeout_cnt.sv
// Saturating phase timer; expired_o is high while the count sits at LIMIT-1.
// Zero latency from count to expired_o; no backpressure (clear wins over enable).
module lockstep_cfg_timeout_cnt #(
  parameter int LIMIT = 256
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int W = (LIMIT > 2) ? $clog2(LIMIT) : 1;
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      cnt <= '0;
    end else if (en_i && (cnt != LAST)) begin
      cnt <= cnt + W'(1);
    end
  end

  assign expired_o = (cnt == LAST);

endmodule

// File: rtl/lockstep_cfg_initiator.sv
// Valid/ready command to single-outstanding req/gnt/r_valid bus initiator; 3-cycle min accept-to-response,
// holds the response until rsp_ready_i. Optional boot write enabled by LOCKSTEP_BOOT_WRITE_EN.
module lockstep_cfg_initiator
  import lockstep_cfg_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int ID_WIDTH       = 2,
  parameter int MY_ID          = 0,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
`ifdef LOCKSTEP_BOOT_WRITE_EN
  ,
  parameter logic [ADDR_WIDTH-1:0] BOOT_ADDR  = '0,
  parameter logic [DATA_WIDTH-1:0] BOOT_WDATA = DATA_WIDTH'(1)
`endif
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic [ADDR_WIDTH-1:0]   cmd_add_i,
  input  logic                    cmd_wen_i,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] cmd_be_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
  output logic                    rsp_err_o,
  output logic                    rsp_timeout_o,
  output logic                    req_o,
  output logic [ADDR_WIDTH-1:0]   add_o,
  output logic                    wen_o,
  output logic [DATA_WIDTH-1:0]   wdata_o,
  output logic [DATA_WIDTH/8-1:0] be_o,
  output logic [ID_WIDTH-1:0]     id_o,
  input  logic                    gnt_i,
  input  logic                    r_valid_i,
  input  logic                    r_opc_i,
  input  logic [ID_WIDTH-1:0]     r_id_i,
  input  logic [DATA_WIDTH-1:0]   r_rdata_i
`ifdef LOCKSTEP_BOOT_WRITE_EN
  ,
  output logic                    boot_err_o
`endif
);

  localparam logic [ID_WIDTH-1:0] MY_ID_V = ID_WIDTH'(MY_ID);
`ifdef LOCKSTEP_BOOT_WRITE_EN
  localparam state_e RST_STATE = BOOT;
`else
  localparam state_e RST_STATE = IDLE;
`endif

  state_e state, state_n;
  logic   cnt_clr, cnt_en, expired;
  logic   accept, granted, r_take, abort, rsp_done, boot_start, in_boot;

  assign id_o        = MY_ID_V;
  assign cmd_ready_o = (state == IDLE) && !rst_i;

  lockstep_cfg_timeout_cnt #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    (cnt_clr),
    .en_i     (cnt_en),
    .expired_o(expired)
  );

  always_comb begin
    state_n    = state;
    cnt_clr    = 1'b0;
    cnt_en     = 1'b0;
    accept     = 1'b0;
    granted    = 1'b0;
    r_take     = 1'b0;
    abort      = 1'b0;
    rsp_done   = 1'b0;
    boot_start = 1'b0;
    unique case (state)
      IDLE: begin
        if (cmd_valid_i) begin
          accept  = 1'b1;
          cnt_clr = 1'b1;
          state_n = REQ;
        end
      end
      REQ: begin
        cnt_en = 1'b1;
        if (gnt_i) begin
          granted = 1'b1;
          cnt_clr = 1'b1;
          state_n = WAIT_R;
        end else if (expired) begin
          abort   = 1'b1;
          state_n = in_boot ? IDLE : RESP;
        end
      end
      WAIT_R: begin
        cnt_en = 1'b1;
        if (r_valid_i && (r_id_i == MY_ID_V)) begin
          r_take  = 1'b1;
          state_n = in_boot ? IDLE : RESP;
        end else if (expired) begin
          abort   = 1'b1;
          state_n = in_boot ? IDLE : RESP;
        end
      end
      RESP: begin
        if (rsp_ready_i) begin
          rsp_done = 1'b1;
          state_n  = IDLE;
        end
      end
`ifdef LOCKSTEP_BOOT_WRITE_EN
      BOOT: begin
        boot_start = 1'b1;
        cnt_clr    = 1'b1;
        state_n    = REQ;
      end
`endif
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= RST_STATE;
      req_o         <= 1'b0;
      add_o         <= '0;
      wen_o         <= WEN_READ;
      wdata_o       <= '0;
      be_o          <= '0;
      rsp_valid_o   <= 1'b0;
      rsp_rdata_o   <= '0;
      rsp_err_o     <= 1'b0;
      rsp_timeout_o <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        req_o   <= 1'b1;
        add_o   <= cmd_add_i;
        wen_o   <= cmd_wen_i;
        wdata_o <= cmd_wdata_i;
        be_o    <= cmd_be_i;
      end
`ifdef LOCKSTEP_BOOT_WRITE_EN
      if (boot_start) begin
        req_o   <= 1'b1;
        add_o   <= BOOT_ADDR;
        wen_o   <= WEN_WRITE;
        wdata_o <= BOOT_WDATA;
        be_o    <= '1;
      end
`endif
      if (granted || abort) begin
        req_o <= 1'b0;
      end
      if (r_take && !in_boot) begin
        rsp_valid_o   <= 1'b1;
        rsp_rdata_o   <= (wen_o == WEN_READ) ? r_rdata_i : '0;
        rsp_err_o     <= r_opc_i;
        rsp_timeout_o <= 1'b0;
      end
      if (abort && !in_boot) begin
        rsp_valid_o   <= 1'b1;
        rsp_rdata_o   <= '0;
        rsp_err_o     <= 1'b0;
        rsp_timeout_o <= 1'b1;
      end
      if (rsp_done) begin
        rsp_valid_o <= 1'b0;
      end
    end
  end

`ifdef LOCKSTEP_BOOT_WRITE_EN
  logic boot_q;

  // Boot status is sticky until reset; the boot response never reaches rsp_*.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      boot_q     <= 1'b0;
      boot_err_o <= 1'b0;
    end else begin
      if (boot_start) begin
        boot_q <= 1'b1;
      end
      if (boot_q && (r_take || abort)) begin
        boot_q     <= 1'b0;
        boot_err_o <= boot_err_o | abort | (r_take & r_opc_i);
      end
    end
  end

  assign in_boot = boot_q;
`else
  assign in_boot = 1'b0;
`endif

endmodule
